event_counter_regs: RTL and testbench

EVENT_COUNTER_REGS -- requirements
Module: event_counter_regs

---
 rtl/event_counter_regs.sv | 167 ++++++++++++++++
 tb/tb_event_counter_regs.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/event_counter_regs.sv
// Event counter block with a small register interface.
// Each channel counts rising edges on its event line. The count saturates at
// all-ones. A sticky status flag is raised when the count reaches the
// programmed threshold, and an interrupt output is derived from the status.
module event_counter_regs #(
  parameter int unsigned N_CH     = 4,
  parameter logic [31:0] ID_VALUE = 32'hEA00_0100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr,
  input  logic            rd,
  input  logic [7:0]      addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  input  logic [N_CH-1:0] event_in,
  output logic            irq
);

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h04;
  localparam logic [7:0] ADDR_THRESH = 8'h08;
  localparam logic [7:0] ADDR_COUNT0 = 8'h10;
  localparam logic [7:0] ADDR_ID     = 8'h3C;

  // Control / configuration state
  logic            r_enable;
  logic            r_irq_en;
  logic [31:0]     r_thresh;
  logic [N_CH-1:0] r_evt_prev;
  logic [31:0]     r_rdata;
  logic            r_irq;

  // Per-channel results gathered from the generate loop
  logic [31:0]     w_count [N_CH];
  logic [N_CH-1:0] w_status;

  // Bus decode. A write always wins over a read in the same cycle.
  logic        w_wr_ctrl;
  logic        w_wr_status;
  logic        w_wr_thresh;
  logic        w_clear;
  logic        w_rd_en;
  logic [31:0] w_rd_value;

  assign w_wr_ctrl   = wr && (addr == ADDR_CTRL);
  assign w_wr_status = wr && (addr == ADDR_STATUS);
  assign w_wr_thresh = wr && (addr == ADDR_THRESH);
  assign w_clear     = w_wr_ctrl && wdata[2];
  assign w_rd_en     = rd && !wr;

  // CTRL register: ENABLE and IRQ_EN. CLEAR is an action bit and is not stored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_enable <= 1'b0;
      r_irq_en <= 1'b0;
    end else if (w_wr_ctrl) begin
      r_enable <= wdata[0];
      r_irq_en <= wdata[1];
    end
  end

  // THRESH register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_thresh <= 32'd0;
    end else if (w_wr_thresh) begin
      r_thresh <= wdata;
    end
  end

  // Previous-cycle sample of the event lines, used for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_evt_prev <= '0;
    end else begin
      r_evt_prev <= event_in;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [31:0] r_count;
      logic        r_status_bit;
      logic        w_edge;
      logic        w_sat;
      logic        w_inc;
      logic        w_hit;
      logic [31:0] w_count_inc;

      assign w_edge      = event_in[gi] && !r_evt_prev[gi];
      assign w_sat       = &r_count;
      // A saturated counter no longer moves, so it cannot "transition" either.
      assign w_inc       = w_edge && r_enable && !w_sat;
      assign w_count_inc = r_count + 32'd1;
      // The flag fires only on the actual step onto THRESH; a CLEAR in the
      // same cycle cancels the step and therefore the hit as well.
      assign w_hit       = w_inc && !w_clear && (r_thresh != 32'd0) &&
                           (w_count_inc == r_thresh);

      // Edge counter with CLEAR taking priority over an increment
      always_ff @(posedge clk) begin
        if (rst) begin
          r_count <= 32'd0;
        end else if (w_clear) begin
          r_count <= 32'd0;
        end else if (w_inc) begin
          r_count <= w_count_inc;
        end
      end

      // Sticky threshold flag; a new hit beats a same-cycle write-1-to-clear
      always_ff @(posedge clk) begin
        if (rst) begin
          r_status_bit <= 1'b0;
        end else if (w_hit) begin
          r_status_bit <= 1'b1;
        end else if (w_wr_status && wdata[gi]) begin
          r_status_bit <= 1'b0;
        end
      end

      assign w_count[gi]  = r_count;
      assign w_status[gi] = r_status_bit;
    end
  endgenerate

  // Read mux over the current (pre-update) register values
  always_comb begin
    w_rd_value = 32'd0;
    case (addr)
      ADDR_CTRL:   w_rd_value = {30'd0, r_irq_en, r_enable};
      ADDR_STATUS: w_rd_value[N_CH-1:0] = w_status;
      ADDR_THRESH: w_rd_value = r_thresh;
      ADDR_ID:     w_rd_value = ID_VALUE;
      default:     w_rd_value = 32'd0;
    endcase
    for (int i = 0; i < int'(N_CH); i++) begin
      if (addr == (ADDR_COUNT0 + 8'(4 * i))) begin
        w_rd_value = w_count[i];
      end
    end
  end

  // Registered read data, held until the next read-only access
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= 32'd0;
    end else if (w_rd_en) begin
      r_rdata <= w_rd_value;
    end
  end

  // Registered interrupt
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_irq_en && (|w_status);
    end
  end

  assign rdata = r_rdata;
  assign irq   = r_irq;

endmodule

// File: tb/tb_event_counter_regs.sv
// Self-checking bench for event_counter_regs: register reads are checked
// against expected values queued when each read is issued.
module tb_event_counter_regs;

  localparam int          N_CH = 4;
  localparam logic [31:0] ID   = 32'hEA00_0100;

  logic            clk;
  logic            rst;
  logic            wr;
  logic            rd;
  logic [7:0]      addr;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic [N_CH-1:0] event_in;
  logic            irq;

  int errors;
  int checks;
  logic [31:0] exp_q [$];

  event_counter_regs #(.N_CH(N_CH), .ID_VALUE(ID)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr       (wr),
    .rd       (rd),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .event_in (event_in),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    wr = 1'b0;
    $display("WR addr=%02h data=%08h", a, d);
  endtask

  // Issues a one-cycle read and queues its expected value; rdata is valid on return.
  task automatic bus_read(input logic [7:0] a, input logic [31:0] e);
    @(negedge clk);
    rd = 1'b1; addr = a;
    exp_q.push_back(e);
    @(negedge clk);
    rd = 1'b0;
    $display("RD addr=%02h data=%08h", a, rdata);
  endtask

  task automatic pulse(input int ch);
    @(negedge clk);
    event_in[ch] = 1'b1;
    @(negedge clk);
    event_in[ch] = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0]  a_tab [5] = '{8'h3C, 8'h00, 8'h04, 8'h10, 8'h08};
    logic [31:0] e_tab [5] = '{ID, 32'd0, 32'd0, 32'd0, 32'd0};
    logic [31:0] e;
    rst = 1'b1; wr = 1'b0; rd = 1'b0; addr = 8'd0; wdata = 32'd0; event_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (rdata !== 32'd0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: rdata=%08h irq=%b, required rdata=0 irq=0", rdata, irq);
    end
    for (int i = 0; i < 5; i++) begin
      bus_read(a_tab[i], e_tab[i]);
      e = exp_q.pop_front();
      checks++;
      if (rdata !== e) begin
        errors++;
        $display("FAIL reset_read[%02h]: got %08h, required %08h", a_tab[i], rdata, e);
      end
    end
  endtask

  task automatic test_counting();
    logic [7:0]  a_tab [4] = '{8'h10, 8'h14, 8'h18, 8'h1C};
    logic [31:0] e_tab [4] = '{32'd4, 32'd2, 32'd0, 32'd0};
    logic [31:0] e;
    bus_write(8'h00, 32'd1);
    repeat (3) pulse(0);
    @(negedge clk);
    event_in[1] = 1'b1;
    repeat (10) @(negedge clk);
    event_in[1] = 1'b0;
    bus_read(8'h10, 32'd3);
    e = exp_q.pop_front();
    checks++;
    if (rdata !== e) begin
      errors++;
      $display("FAIL count0_pulses: got %08h, required %08h", rdata, e);
    end
    bus_read(8'h14, 32'd1);
    e = exp_q.pop_front();
    checks++;
    if (rdata !== e) begin
      errors++;
      $display("FAIL count1_level: got %08h, required %08h", rdata, e);
    end
    // Both channels rising in the same cycle
    @(negedge clk);
    event_in[1:0] = 2'b11;
    @(negedge clk);
    event_in[1:0] = 2'b00;
    for (int i = 0; i < 4; i++) begin
      bus_read(a_tab[i], e_tab[i]);
      e = exp_q.pop_front();
      checks++;
      if (rdata !== e) begin
        errors++;
        $display("FAIL concurrent_count[%02h]: got %08h, required %08h", a_tab[i], rdata, e);
      end
    end
  endtask

  task automatic test_threshold();
    logic [31:0] e;
    bus_write(8'h08, 32'd2);
    bus_write(8'h00, 32'd7);          // CLEAR + IRQ_EN + ENABLE
    bus_read(8'h00, 32'd3);
    e = exp_q.pop_front();
    checks++;
    if (rdata !== e) begin
      errors++;
      $display("FAIL ctrl_after_clear: got %08h, required %08h", rdata, e);
    end
    pulse(2);
    @(negedge clk);
    event_in[2] = 1'b1;
    @(negedge clk);
    event_in[2] = 1'b0;
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_latency_early: irq=%b, required 0", irq);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_set: irq=%b, required 1", irq);
    end
    bus_read(8'h04, 32'd4);
    e = exp_q.pop_front();
    checks++;
    if (rdata !== e) begin
      errors++;
      $display("FAIL status_hit: got %08h, required %08h", rdata, e);
    end
    bus_write(8'h04, 32'd4);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_hold_after_w1c: irq=%b, required 1", irq);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_clear: irq=%b, required 0", irq);
    end
    bus_write(8'h08, 32'd2);          // rewriting THRESH must not re-raise the flag
    repeat (2) @(negedge clk);
    bus_read(8'h04, 32'd0);
    e = exp_q.pop_front();
    checks++;
    if (rdata !== e) begin
      errors++;
      $display("FAIL status_w1c: got %08h, required %08h", rdata, e);
    end
    // Hit on channel 2 in the same cycle as a W1C of that bit: the hit wins
    bus_write(8'h08, 32'd3);
    @(negedge clk);
    event_in[2] = 1'b1; wr = 1'b1; addr = 8'h04; wdata = 32'd4;
    @(negedge clk);
    event_in[2] = 1'b0; wr = 1'b0;
    $display("WR addr=04 data=00000004 with event on ch2");
    bus_read(8'h04, 32'd4);
    e = exp_q.pop_front();
    checks++;
    if (rdata !== e) begin
      errors++;
      $display("FAIL status_set_priority: got %08h, required %08h", rdata, e);
    end
  endtask

  task automatic test_disable_clear();
    logic [31:0] e;
    bus_write(8'h00, 32'd0);
    repeat (5) pulse(3);
    bus_write(8'h00, 32'd1);
    repeat (3) @(negedge clk);
    bus_read(8'h1C, 32'd0);
    e = exp_q.pop_front();
    checks++;
    if (rdata !== e) begin
      errors++;
      $display("FAIL count3_disabled: got %08h, required %08h", rdata, e);
    end
    pulse(0);
    bus_read(8'h10, 32'd1);
    e = exp_q.pop_front();
    checks++;
    if (rdata !== e) begin
      errors++;
      $display("FAIL count0_before_clear: got %08h, required %08h", rdata, e);
    end
    @(negedge clk);
    event_in[0] = 1'b1; wr = 1'b1; addr = 8'h00; wdata = 32'd5;
    @(negedge clk);
    event_in[0] = 1'b0; wr = 1'b0;
    $display("WR addr=00 data=00000005 with event on ch0");
    bus_read(8'h10, 32'd0);
    e = exp_q.pop_front();
    checks++;
    if (rdata !== e) begin
      errors++;
      $display("FAIL clear_priority: got %08h, required %08h", rdata, e);
    end
    bus_read(8'h00, 32'd1);
    e = exp_q.pop_front();
    checks++;
    if (rdata !== e) begin
      errors++;
      $display("FAIL ctrl_after_clear_write: got %08h, required %08h", rdata, e);
    end
    bus_read(8'h04, 32'd4);
    e = exp_q.pop_front();
    checks++;
    if (rdata !== e) begin
      errors++;
      $display("FAIL status_kept_on_clear: got %08h, required %08h", rdata, e);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] e;
    @(negedge clk);
    force dut.g_ch[0].r_count = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.g_ch[0].r_count;
    pulse(0);
    bus_read(8'h10, 32'hFFFF_FFFF);
    e = exp_q.pop_front();
    checks++;
    if (rdata !== e) begin
      errors++;
      $display("FAIL count0_reach_max: got %08h, required %08h", rdata, e);
    end
    pulse(0);
    bus_read(8'h10, 32'hFFFF_FFFF);
    e = exp_q.pop_front();
    checks++;
    if (rdata !== e) begin
      errors++;
      $display("FAIL count0_saturate: got %08h, required %08h", rdata, e);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0]  a_tab [8] = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h99};
    logic [31:0] e;
    bus_write(8'h00, 32'd3);
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_before_reset: irq=%b, required 1", irq);
    end
    bus_read(8'h3C, ID);
    e = exp_q.pop_front();
    checks++;
    if (rdata !== e) begin
      errors++;
      $display("FAIL id_before_reset: got %08h, required %08h", rdata, e);
    end
    repeat (3) begin
      @(negedge clk);
      event_in[1] = ~event_in[1];
    end
    @(negedge clk);
    event_in[1] = ~event_in[1];
    rst = 1'b1; wr = 1'b1; addr = 8'h08; wdata = 32'h0000_00FF;
    @(negedge clk);
    rst = 1'b0; wr = 1'b0;
    event_in[1] = 1'b1;
    checks++;
    if (rdata !== 32'd0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: rdata=%08h irq=%b, required rdata=0 irq=0", rdata, irq);
    end
    repeat (2) @(negedge clk);
    event_in[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus_read(a_tab[i], 32'd0);
      e = exp_q.pop_front();
      checks++;
      if (rdata !== e) begin
        errors++;
        $display("FAIL mid_reset_read[%02h]: got %08h, required %08h", a_tab[i], rdata, e);
      end
    end
    bus_write(8'h3C, 32'h1234_5678);  // ID is read-only
    bus_read(8'h3C, ID);
    e = exp_q.pop_front();
    checks++;
    if (rdata !== e) begin
      errors++;
      $display("FAIL id_readonly: got %08h, required %08h", rdata, e);
    end
    @(negedge clk);
    wr = 1'b1; rd = 1'b1; addr = 8'h08; wdata = 32'h0000_1234;
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
    $display("WR+RD addr=08 data=00001234 rdata=%08h", rdata);
    checks++;
    if (rdata !== ID) begin
      errors++;
      $display("FAIL wr_rd_collision_rdata: got %08h, required %08h", rdata, ID);
    end
    bus_read(8'h08, 32'h0000_1234);
    e = exp_q.pop_front();
    checks++;
    if (rdata !== e) begin
      errors++;
      $display("FAIL wr_rd_collision_thresh: got %08h, required %08h", rdata, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    @(negedge clk);
    rd = 1'b1; addr = 8'h3C; exp_q.push_back(ID);
    @(negedge clk);
    e = exp_q.pop_front();
    $display("RD addr=3C data=%08h", rdata);
    checks++;
    if (rdata !== e) begin
      errors++;
      $display("FAIL b2b_first: got %08h, required %08h", rdata, e);
    end
    addr = 8'h08; exp_q.push_back(32'h0000_1234);
    @(negedge clk);
    rd = 1'b0;
    e = exp_q.pop_front();
    $display("RD addr=08 data=%08h", rdata);
    checks++;
    if (rdata !== e) begin
      errors++;
      $display("FAIL b2b_second: got %08h, required %08h", rdata, e);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (rdata !== 32'h0000_1234) begin
      errors++;
      $display("FAIL rdata_hold: got %08h, required %08h", rdata, 32'h0000_1234);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_counting();
    test_threshold();
    test_disable_clear();
    test_saturation();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
